// File: rtl/gemm_pkg.sv
// Shared constants, FSM state encoding and helpers for the systolic GEMM controller.
package gemm_pkg;
    localparam int GEMM_N    = 4;
    localparam int GEMM_KMAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } gemm_state_e;

    // A reduction depth is usable only when it lies in 1..kmax.
    function automatic logic k_in_range(input int k, input int kmax);
        return (k >= 32'sd1) && (k <= kmax);
    endfunction
endpackage

// File: rtl/systolic_gemm_ctrl_if.sv
// Job-control and result-drain bundle between a requester (master) and the controller (slave).
interface systolic_gemm_ctrl_if import gemm_pkg::*; #(
    parameter int N    = GEMM_N,
    parameter int KMAX = GEMM_KMAX
) ();
    logic                    start_i;
    logic [$clog2(KMAX):0]   k_len_i;
    logic                    abort_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic                    rd_en_o;
    logic [$clog2(KMAX)-1:0] rd_addr_o;
    logic [N-1:0]            lane_vld_o;
    logic                    acc_clr_o;
    logic                    acc_en_o;
    logic [$clog2(N)-1:0]    out_row_o;
    logic                    out_valid_o;
    logic                    out_ready_i;

    modport master (
        output start_i, k_len_i, abort_i, out_ready_i,
        input  busy_o, done_o, err_o, rd_en_o, rd_addr_o, lane_vld_o,
               acc_clr_o, acc_en_o, out_row_o, out_valid_o
    );

    modport slave (
        input  start_i, k_len_i, abort_i, out_ready_i,
        output busy_o, done_o, err_o, rd_en_o, rd_addr_o, lane_vld_o,
               acc_clr_o, acc_en_o, out_row_o, out_valid_o
    );
endinterface

// File: rtl/gemm_skew_gen.sv
// Diagonal operand-valid skew: lane r is live for feed phases r..r+K-1.
module gemm_skew_gen #(
    parameter int N  = 4,
    parameter int CW = 7
) (
    input  logic          feed_s,
    input  logic [CW-1:0] t_s,
    input  logic [CW-1:0] k_s,
    output logic [N-1:0]  lane_vld_s
);
    // Per-lane window decode
    always_comb begin
        lane_vld_s = '0;
        for (int r = 0; r < N; r++) begin
            if (feed_s && (t_s >= CW'(r)) && ((t_s - CW'(r)) < k_s)) begin
                lane_vld_s[r] = 1'b1;
            end else begin
                lane_vld_s[r] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/systolic_gemm_ctrl.sv
// Job sequencer for an NxN systolic GEMM array: clear, skewed feed, flush, row drain.
module systolic_gemm_ctrl import gemm_pkg::*; #(
    parameter int N    = GEMM_N,
    parameter int KMAX = GEMM_KMAX
) (
    input logic                clk,
    input logic                rst_n,
    systolic_gemm_ctrl_if.slave bus
);
    localparam int AW = $clog2(KMAX);
    localparam int CW = $clog2(KMAX + N);
    localparam int RW = $clog2(N);

    gemm_state_e   state_r, nxt_state_s;
    logic [CW-1:0] cnt_r, nxt_cnt_s;
    logic [CW-1:0] k_r, nxt_k_s;
    logic [CW-1:0] feed_last_s;
    logic          k_ok_s;

    logic          busy_s, done_s, err_s, rd_en_s, acc_clr_s, acc_en_s, out_valid_s;
    logic [AW-1:0] rd_addr_s;
    logic [RW-1:0] out_row_s;
    logic [N-1:0]  lane_s;

    assign k_ok_s      = k_in_range(int'(bus.k_len_i), KMAX);
    assign feed_last_s = k_r + CW'(N) - CW'(2);

    // State, phase counter and latched depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            k_r     <= '0;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            k_r     <= nxt_k_s;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_k_s     = k_r;
        if ((state_r != ST_IDLE) && bus.abort_i) begin
            nxt_state_s = ST_IDLE;
            nxt_cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i && k_ok_s) begin
                        nxt_state_s = ST_CLEAR;
                        nxt_k_s     = CW'(bus.k_len_i);
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    nxt_state_s = ST_FEED;
                    nxt_cnt_s   = '0;
                end
                ST_FEED: begin
                    if (cnt_r == feed_last_s) begin
                        nxt_state_s = ST_FLUSH;
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_cnt_s = cnt_r + CW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == CW'(N - 1)) begin
                        nxt_state_s = ST_DRAIN;
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_cnt_s = cnt_r + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_valid_o && bus.out_ready_i) begin
                        if (cnt_r == CW'(N - 1)) begin
                            nxt_state_s = ST_DONE;
                            nxt_cnt_s   = '0;
                        end else begin
                            nxt_cnt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        nxt_cnt_s = cnt_r;
                    end
                end
                ST_DONE: begin
                    nxt_state_s = ST_IDLE;
                    nxt_cnt_s   = '0;
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                    nxt_cnt_s   = '0;
                end
            endcase
        end
    end

    gemm_skew_gen #(.N(N), .CW(CW)) u_skew (
        .feed_s     (nxt_state_s == ST_FEED),
        .t_s        (nxt_cnt_s),
        .k_s        (nxt_k_s),
        .lane_vld_s (lane_s)
    );

    // Output decode from the upcoming state so every output can be a flop
    always_comb begin
        busy_s      = (nxt_state_s != ST_IDLE);
        done_s      = (nxt_state_s == ST_DONE);
        err_s       = (state_r == ST_IDLE) && bus.start_i && !k_ok_s;
        acc_clr_s   = (nxt_state_s == ST_CLEAR);
        acc_en_s    = (nxt_state_s == ST_FEED) || (nxt_state_s == ST_FLUSH);
        out_valid_s = (nxt_state_s == ST_DRAIN);
        rd_en_s     = 1'b0;
        rd_addr_s   = '0;
        if ((nxt_state_s == ST_FEED) && (nxt_cnt_s < nxt_k_s)) begin
            rd_en_s   = 1'b1;
            rd_addr_s = AW'(nxt_cnt_s);
        end else if (nxt_state_s == ST_FEED) begin
            rd_addr_s = bus.rd_addr_o;
        end else begin
            rd_addr_s = '0;
        end
        if (out_valid_s) begin
            out_row_s = RW'(nxt_cnt_s);
        end else begin
            out_row_s = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.rd_en_o     <= 1'b0;
            bus.rd_addr_o   <= '0;
            bus.lane_vld_o  <= '0;
            bus.acc_clr_o   <= 1'b0;
            bus.acc_en_o    <= 1'b0;
            bus.out_row_o   <= '0;
            bus.out_valid_o <= 1'b0;
        end else begin
            bus.busy_o      <= busy_s;
            bus.done_o      <= done_s;
            bus.err_o       <= err_s;
            bus.rd_en_o     <= rd_en_s;
            bus.rd_addr_o   <= rd_addr_s;
            bus.lane_vld_o  <= lane_s;
            bus.acc_clr_o   <= acc_clr_s;
            bus.acc_en_o    <= acc_en_s;
            bus.out_row_o   <= out_row_s;
            bus.out_valid_o <= out_valid_s;
        end
    end
endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// Scoreboard bench: stimulus queues timed expectations, a negedge monitor consumes them.
module tb_systolic_gemm_ctrl;
    import gemm_pkg::*;
    localparam int N    = GEMM_N;
    localparam int KMAX = GEMM_KMAX;

    localparam int K_CLR  = 0;
    localparam int K_BUSY = 1;
    localparam int K_RD   = 2;
    localparam int K_LANE = 3;
    localparam int K_EN   = 4;
    localparam int K_ROW  = 5;
    localparam int K_HOLD = 6;
    localparam int K_DONE = 7;
    localparam int K_ERR  = 8;

    typedef struct {
        int kind;
        int c;
        int v;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    systolic_gemm_ctrl_if #(.N(N), .KMAX(KMAX)) bus ();

    systolic_gemm_ctrl #(.N(N), .KMAX(KMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            K_CLR:   return "acc_clr";
            K_BUSY:  return "busy";
            K_RD:    return "rd_addr";
            K_LANE:  return "lane_vld";
            K_EN:    return "acc_en";
            K_ROW:   return "out_row";
            K_HOLD:  return "row_hold";
            K_DONE:  return "done";
            K_ERR:   return "err";
            default: return "unknown";
        endcase
    endfunction

    function automatic int all_outs();
        return int'({bus.busy_o, bus.done_o, bus.err_o, bus.rd_en_o, bus.rd_addr_o,
                     bus.lane_vld_o, bus.acc_clr_o, bus.acc_en_o, bus.out_row_o,
                     bus.out_valid_o});
    endfunction

    // Diagonal window straight from the lane rule r <= t <= r+K-1
    function automatic int lanes(input int t, input int k);
        int v = 0;
        for (int r = 0; r < N; r++) begin
            if (t >= r && t <= r + k - 1) v = v | (1 << r);
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int kind, input int v);
        int idx = -1;
        n_tests++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        end
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s: unexpected output value %0d at cycle %0d", kname(kind), v, cyc);
        end else begin
            if (exp_q[idx].c != cyc || exp_q[idx].v != v) begin
                n_fail++;
                $display("FAIL %s: got value %0d at cycle %0d, expected value %0d at cycle %0d",
                         kname(kind), v, cyc, exp_q[idx].v, exp_q[idx].c);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: every active output must match the next expectation of its kind
    always @(negedge clk) begin
        if (bus.acc_clr_o) pop_cmp(K_CLR, 1);
        if (bus.busy_o) pop_cmp(K_BUSY, 1);
        if (bus.rd_en_o) pop_cmp(K_RD, int'(bus.rd_addr_o));
        if (bus.lane_vld_o != '0) pop_cmp(K_LANE, int'(bus.lane_vld_o));
        if (bus.acc_en_o) pop_cmp(K_EN, 1);
        if (bus.out_valid_o && bus.out_ready_i) pop_cmp(K_ROW, int'(bus.out_row_o));
        if (bus.out_valid_o && !bus.out_ready_i) pop_cmp(K_HOLD, int'(bus.out_row_o));
        if (bus.done_o) pop_cmp(K_DONE, 1);
        if (bus.err_o) pop_cmp(K_ERR, 1);
    end

    task automatic push_if(input int kind, input int c, input int v, input int cut);
        ev_t e;
        if (c <= cut) begin
            e.kind = kind;
            e.c    = c;
            e.v    = v;
            exp_q.push_back(e);
        end
    endtask

    // Timeline for a job whose start was sampled at the end of cycle s
    task automatic expect_job(input int s, input int k, input int sr, input int sc, input int cut);
        int d0 = s + k + 2 * N + 1;
        push_if(K_CLR, s + 1, 1, cut);
        for (int c = s + 1; c <= d0 + N + sc; c++) push_if(K_BUSY, c, 1, cut);
        for (int t = 0; t < k + N - 1; t++) begin
            if (t < k) push_if(K_RD, s + 2 + t, t, cut);
            if (lanes(t, k) != 0) push_if(K_LANE, s + 2 + t, lanes(t, k), cut);
        end
        for (int c = s + 2; c <= s + k + 2 * N; c++) push_if(K_EN, c, 1, cut);
        for (int r = 0; r < N; r++) push_if(K_ROW, d0 + r + ((r >= sr) ? sc : 0), r, cut);
        for (int i = 0; i < sc; i++) push_if(K_HOLD, d0 + sr + i, sr, cut);
        push_if(K_DONE, d0 + N + sc, 1, cut);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse(input int k, output int s);
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.k_len_i = 7'(k);
        s = cyc;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic bad_start(input int k);
        int s;
        start_pulse(k, s);
        push_if(K_ERR, s + 1, 1, s + 1);
        chk("err_busy", int'(bus.busy_o), 0);
        wait_cyc(s + 3);
        chk("err_idle_busy", int'(bus.busy_o), 0);
        chk("err_pending", exp_q.size(), 0);
    endtask

    // ab >= 0 aborts at feed phase ab; rs resets during drain; poke retries start mid-job
    task automatic run_job(input int k, input int sr, input int sc, input int ab,
                           input bit rs, input bit poke);
        int s, d0, done_c, cut;
        start_pulse(k, s);
        d0     = s + k + 2 * N + 1;
        done_c = d0 + N + sc;
        cut    = done_c;
        if (ab >= 0) cut = s + 2 + ab;
        if (rs) cut = d0;
        expect_job(s, k, sr, sc, cut);
        if (poke) begin
            wait_cyc(s + 3);
            bus.start_i = 1'b1;
            bus.k_len_i = 7'd0;
            wait_cyc(s + 4);
            bus.start_i = 1'b0;
        end
        if (ab >= 0) begin
            wait_cyc(s + 2 + ab);
            bus.abort_i = 1'b1;
            wait_cyc(s + 3 + ab);
            bus.abort_i = 1'b0;
            chk("abort_outs", all_outs(), 0);
            wait_cyc(s + 3 + ab + 25);
        end else if (rs) begin
            wait_cyc(d0 + 1);
            rst_n = 1'b0;
            #1;
            chk("reset_drain_outs", all_outs(), 0);
            wait_cyc(d0 + 4);
            rst_n = 1'b1;
            wait_cyc(d0 + 30);
        end else begin
            if (sc > 0) begin
                wait_cyc(d0 + sr);
                bus.out_ready_i = 1'b0;
                wait_cyc(d0 + sr + sc);
                bus.out_ready_i = 1'b1;
            end
            wait_cyc(done_c + 2);
            chk("post_job_busy", int'(bus.busy_o), 0);
        end
        chk("job_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.k_len_i     = 7'd0;
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;

        run_job(4, 0, 0, -1, 1'b0, 1'b1);
        bad_start(0);
        bad_start(65);
        run_job(1, 0, 0, -1, 1'b0, 1'b0);
        run_job(4, 2, 3, -1, 1'b0, 1'b0);
        run_job(4, 0, 0, 2, 1'b0, 1'b0);
        run_job(3, 0, 0, -1, 1'b0, 1'b0);
        run_job(2, 0, 0, -1, 1'b1, 1'b0);
        run_job(KMAX, 0, 0, -1, 1'b0, 1'b0);
        run_job(5, 1, 2, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
